// File: rtl/elevator_ctrl.sv
// elevator_ctrl: Moore controller for a single car serving floors 0-3.
// The state register and the 8-bit door counter clear asynchronously on
// reset=0. Outputs decode the state register only.
// Optional build macro ELEV_SAME_FLOOR_DOOR_EN: when defined, an IDLE request
// whose target equals the current floor opens the door; when undefined, that
// request is ignored.
module elevator_ctrl #(
   parameter int unsigned DOOR_OPEN_CYCLES = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       up_request,
   input  logic       down_request,
   input  logic [1:0] current_floor,
   input  logic [1:0] target_floor,
   input  logic       emergency_stop,
   output logic       move_up,
   output logic       move_down,
   output logic       door_open,
   output logic       stopped,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE        = 3'b000,
      S_MOVING_UP   = 3'b001,
      S_MOVING_DOWN = 3'b010,
      S_DOOR_OPEN   = 3'b011,
      S_EMERGENCY   = 3'b100
   } state_t;

   localparam logic [7:0] DOOR_LAST = 8'(DOOR_OPEN_CYCLES - 1);

   state_t     r_state;
   logic [7:0] r_door_cnt;
   state_t     w_next_state;
   logic [7:0] w_next_cnt;
   logic       w_same_floor_req;

`ifdef ELEV_SAME_FLOOR_DOOR_EN
   assign w_same_floor_req = (up_request || down_request) && (target_floor == current_floor);
`else
   assign w_same_floor_req = 1'b0;
`endif

   // State register and door counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_door_cnt <= '0;
      end else begin
         r_state    <= w_next_state;
         r_door_cnt <= w_next_cnt;
      end
   end

   // Next-state and counter logic; counter stays zero outside DOOR_OPEN so entry loads 0
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = '0;
      if (emergency_stop) begin
         w_next_state = S_EMERGENCY;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (up_request && (target_floor > current_floor))
                  w_next_state = S_MOVING_UP;
               else if (down_request && (target_floor < current_floor))
                  w_next_state = S_MOVING_DOWN;
               else if (w_same_floor_req)
                  w_next_state = S_DOOR_OPEN;
            end
            S_MOVING_UP: begin
               if (current_floor >= target_floor)
                  w_next_state = S_DOOR_OPEN;
            end
            S_MOVING_DOWN: begin
               if (current_floor <= target_floor)
                  w_next_state = S_DOOR_OPEN;
            end
            S_DOOR_OPEN: begin
               if (r_door_cnt == DOOR_LAST)
                  w_next_state = S_IDLE;
               else
                  w_next_cnt = r_door_cnt + 8'd1;
            end
            S_EMERGENCY: w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
         endcase
      end
   end

   // Output decode from the registered state
   always_comb begin
      move_up   = 1'b0;
      move_down = 1'b0;
      door_open = 1'b0;
      stopped   = 1'b0;
      case (r_state)
         S_IDLE:        stopped   = 1'b1;
         S_MOVING_UP:   move_up   = 1'b1;
         S_MOVING_DOWN: move_down = 1'b1;
         S_DOOR_OPEN: begin
            door_open = 1'b1;
            stopped   = 1'b1;
         end
         S_EMERGENCY:   stopped   = 1'b1;
         default:       stopped   = 1'b1;
      endcase
   end

   assign state = r_state;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: directed vector table, same-floor sequence,
// async reset checks and randomized traffic against a behavioural model.
module tb_elevator_ctrl;

   localparam int N = 3;
`ifdef ELEV_SAME_FLOOR_DOOR_EN
   localparam bit SAME_EN = 1'b1;
`else
   localparam bit SAME_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       up_request = 1'b0;
   logic       down_request = 1'b0;
   logic [1:0] current_floor = '0;
   logic [1:0] target_floor = '0;
   logic       emergency_stop = 1'b0;
   logic       move_up, move_down, door_open, stopped;
   logic [2:0] state;

   int total = 0;
   int bad = 0;

   elevator_ctrl #(.DOOR_OPEN_CYCLES(N)) dut (
      .clk           (clk),
      .reset         (reset),
      .up_request    (up_request),
      .down_request  (down_request),
      .current_floor (current_floor),
      .target_floor  (target_floor),
      .emergency_stop(emergency_stop),
      .move_up       (move_up),
      .move_down     (move_down),
      .door_open     (door_open),
      .stopped       (stopped),
      .state         (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic       up;
      logic       dn;
      logic [1:0] cur;
      logic [1:0] tgt;
      logic       es;
      logic [2:0] exp_state;
   } vec_t;

   vec_t vecs[$];

   // Expected {state, move_up, move_down, door_open, stopped} for a state code
   function automatic logic [6:0] expect_of(input logic [2:0] code);
      case (code)
         3'd0:    return {code, 4'b0001};
         3'd1:    return {code, 4'b1000};
         3'd2:    return {code, 4'b0100};
         3'd3:    return {code, 4'b0011};
         3'd4:    return {code, 4'b0001};
         default: return {code, 4'b0001};
      endcase
   endfunction

   task automatic check(input string name, input logic [2:0] exp_code);
      logic [6:0] act, exp;
      act = {state, move_up, move_down, door_open, stopped};
      exp = expect_of(exp_code);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got state=%b up=%b dn=%b door=%b stop=%b, want state=%b up=%b dn=%b door=%b stop=%b",
                  name, act[6:4], act[3], act[2], act[1], act[0],
                  exp[6:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic add(input logic r, input logic u, input logic d, input logic [1:0] c,
                      input logic [1:0] t, input logic e, input logic [2:0] s);
      vec_t v;
      v.rst_n = r; v.up = u; v.dn = d; v.cur = c; v.tgt = t; v.es = e; v.exp_state = s;
      vecs.push_back(v);
   endtask

   // Behavioural model: motion direction, remaining door cycles, emergency flag
   int  m_dir;
   int  m_door_left;
   bit  m_emerg;

   function automatic logic [2:0] model_code();
      if (m_emerg)          return 3'd4;
      if (m_door_left > 0)  return 3'd3;
      if (m_dir > 0)        return 3'd1;
      if (m_dir < 0)        return 3'd2;
      return 3'd0;
   endfunction

   task automatic model_reset();
      m_dir = 0; m_door_left = 0; m_emerg = 1'b0;
   endtask

   task automatic model_step(input bit r, input bit u, input bit d, input int c,
                             input int t, input bit e);
      if (!r) begin
         model_reset();
      end else if (e) begin
         m_emerg = 1'b1; m_dir = 0; m_door_left = 0;
      end else if (m_emerg) begin
         m_emerg = 1'b0;
      end else if (m_door_left > 0) begin
         m_door_left--;
      end else if (m_dir != 0) begin
         if ((m_dir > 0 && c >= t) || (m_dir < 0 && c <= t)) begin
            m_dir = 0; m_door_left = N;
         end
      end else begin
         if (u && t > c)                           m_dir = 1;
         else if (d && t < c)                      m_dir = -1;
         else if ((u || d) && t == c && SAME_EN)   m_door_left = N;
      end
   endtask

   initial begin
      // reset, up trip, down trip, emergencies, ignored requests, reset from emergency
      add(0,0,0,2'd1,2'd2,1, 3'd0);
      add(1,1,0,2'd2,2'd3,0, 3'd1);
      add(1,0,0,2'd3,2'd3,0, 3'd3);
      add(1,0,0,2'd3,2'd3,0, 3'd3);
      add(1,0,0,2'd3,2'd3,0, 3'd3);
      add(1,0,0,2'd3,2'd3,0, 3'd0);
      add(1,0,1,2'd3,2'd1,0, 3'd2);
      add(1,0,0,2'd1,2'd1,0, 3'd3);
      add(1,0,0,2'd1,2'd1,0, 3'd3);
      add(1,0,0,2'd1,2'd1,0, 3'd3);
      add(1,0,0,2'd1,2'd1,0, 3'd0);
      add(1,0,0,2'd1,2'd1,1, 3'd4);
      add(1,0,0,2'd1,2'd1,1, 3'd4);
      add(1,0,0,2'd1,2'd1,0, 3'd0);
      add(1,1,0,2'd2,2'd3,0, 3'd1);
      add(1,0,0,2'd2,2'd3,1, 3'd4);
      add(1,0,0,2'd3,2'd3,0, 3'd0);
      add(1,0,0,2'd3,2'd3,0, 3'd0);
      add(1,1,0,2'd3,2'd1,0, 3'd0);
      add(1,0,1,2'd0,2'd2,0, 3'd0);
      add(1,0,1,2'd2,2'd0,0, 3'd2);
      add(1,0,1,2'd1,2'd0,0, 3'd2);
      add(1,0,0,2'd0,2'd0,0, 3'd3);
      add(1,1,0,2'd0,2'd3,0, 3'd3);
      add(1,1,0,2'd0,2'd3,0, 3'd3);
      add(1,1,0,2'd0,2'd3,0, 3'd0);
      add(1,1,0,2'd0,2'd3,0, 3'd1);
      add(1,0,0,2'd1,2'd3,1, 3'd4);
      add(0,0,0,2'd1,2'd3,1, 3'd0);
      add(1,0,0,2'd1,2'd3,0, 3'd0);

      foreach (vecs[i]) begin
         @(negedge clk);
         reset = vecs[i].rst_n; up_request = vecs[i].up; down_request = vecs[i].dn;
         current_floor = vecs[i].cur; target_floor = vecs[i].tgt; emergency_stop = vecs[i].es;
         if (vecs[i].rst_n) begin
            @(posedge clk);
            #1;
         end else begin
            #1;
         end
         check($sformatf("vec%0d", i), vecs[i].exp_state);
      end

      // same-floor request: opens the door only with the feature enabled
      @(negedge clk);
      up_request = 1'b1; down_request = 1'b0; current_floor = 2'd2; target_floor = 2'd2;
      @(posedge clk); #1;
      check("same_up_0", SAME_EN ? 3'd3 : 3'd0);
      @(negedge clk); up_request = 1'b0;
      @(posedge clk); #1;
      check("same_up_1", SAME_EN ? 3'd3 : 3'd0);
      @(posedge clk); #1;
      check("same_up_2", SAME_EN ? 3'd3 : 3'd0);
      @(posedge clk); #1;
      check("same_up_3", 3'd0);
      @(negedge clk); down_request = 1'b1; current_floor = 2'd0; target_floor = 2'd0;
      @(posedge clk); #1;
      check("same_dn_0", SAME_EN ? 3'd3 : 3'd0);
      @(negedge clk); down_request = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("same_dn_end", 3'd0);

      // async reset mid-motion, between clock edges
      @(negedge clk); up_request = 1'b1; current_floor = 2'd0; target_floor = 2'd3;
      @(posedge clk); #1;
      check("pre_reset_move", 3'd1);
      #2; reset = 1'b0; #1;
      check("async_reset_mid_move", 3'd0);
      @(negedge clk); reset = 1'b1; up_request = 1'b0;

      // randomized traffic against the model
      model_reset();
      @(posedge clk); #1;
      for (int unsigned k = 0; k < 600; k++) begin
         @(negedge clk);
         up_request     = ($urandom_range(0, 2) == 0);
         down_request   = ($urandom_range(0, 2) == 0);
         current_floor  = 2'($urandom_range(0, 3));
         target_floor   = 2'($urandom_range(0, 3));
         emergency_stop = ($urandom_range(0, 15) == 0);
         reset          = ($urandom_range(0, 59) != 0);
         if (!reset) begin
            #1;
            model_reset();
            check($sformatf("rand_async_rst%0d", k), model_code());
         end
         @(posedge clk);
         model_step(reset, up_request, down_request, int'(current_floor),
                    int'(target_floor), emergency_stop);
         #1;
         check($sformatf("rand%0d", k), model_code());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/elevator_ctrl.md
Name: elevator_ctrl

Overview:
- Moore-style controller for a single elevator car serving 4 floors (0-3).
- Takes up/down requests toward a target floor and the externally sensed current floor.
- Drives motor direction, door and stopped indications, plus a 3-bit state code for debug/observation.
- Sits between the floor sensor/call-button logic and the motor/door drivers.

Parameters:
- DOOR_OPEN_CYCLES, 3, clock cycles the door stays open before returning to IDLE; legal range 1-255.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- up_request  input  1  request travel upward to target_floor; level-sampled.
- down_request  input  1  request travel downward to target_floor; level-sampled.
- current_floor  input  2  floor the car is currently at (0-3).
- target_floor  input  2  requested destination floor (0-3).
- emergency_stop  input  1  level; forces EMERGENCY while high.
- move_up  output  1  motor up command.
- move_down  output  1  motor down command.
- door_open  output  1  door open command.
- stopped  output  1  car stationary.
- state  output  3  current FSM state code.

Behaviour:
- One clock domain, clocked by clk. reset is asynchronous and active-low.
- State register plus an 8-bit door counter, both cleared asynchronously when reset=0.
- Outputs are a pure decode of the state register; no input reaches an output combinationally.
- State encodings: IDLE=000, MOVING_UP=001, MOVING_DOWN=010, DOOR_OPEN=011, EMERGENCY=100. Codes 101-111 recover to IDLE on the next edge.
- Output decode per state:
  - IDLE: stopped=1, others 0.
  - MOVING_UP: move_up=1, others 0.
  - MOVING_DOWN: move_down=1, others 0.
  - DOOR_OPEN: door_open=1, stopped=1.
  - EMERGENCY: stopped=1, door_open=0, both move outputs 0.
- During reset: state=IDLE and counter=0, so stopped=1 and move_up=move_down=door_open=0.
- emergency_stop=1 has top priority in every state: next state is EMERGENCY and the counter is cleared.
- IDLE transitions, checked in this order:
  - up_request=1 and target_floor>current_floor -> MOVING_UP.
  - Else down_request=1 and target_floor<current_floor -> MOVING_DOWN.
  - Else (up_request or down_request)=1 and target_floor==current_floor -> DOOR_OPEN.
  - Otherwise stay in IDLE.
  - A request pointing the wrong way (e.g. up_request with target<current) is ignored.
  - Requests are not latched; a request must be high at the sampling edge.
- MOVING_UP: if current_floor>=target_floor -> DOOR_OPEN (stop at the current floor); else stay.
- MOVING_DOWN: if current_floor<=target_floor -> DOOR_OPEN; else stay.
- DOOR_OPEN timing:
  - The counter is loaded with 0 on entry and increments each cycle.
  - When counter==DOOR_OPEN_CYCLES-1 -> IDLE, so door_open is high for exactly DOOR_OPEN_CYCLES cycles.
  - Requests are ignored while the door is open.
- EMERGENCY: remain while emergency_stop=1; on the first edge with emergency_stop=0 -> IDLE, never directly back to motion. Mid-motion emergency halts the motor on the next edge.
- Latency: one edge from qualifying input to state and output change.
- reset asserted mid-operation returns to IDLE immediately, asynchronously.

Optional Feature:
- Macro: ELEV_SAME_FLOOR_DOOR_EN.
- Defined: an IDLE request with target_floor==current_floor opens the door (DOOR_OPEN), as described above.
- Undefined: such a request is ignored and the FSM stays in IDLE; all other behaviour is identical.

Test Plan:
- Reset: reset=0 with arbitrary inputs -> state=000, stopped=1, move_up=move_down=door_open=0, immediately and without waiting for a clk edge.
- Up trip:
  - current=2, target=3, up_request=1 -> next edge state=001, move_up=1.
  - Set current=3 -> next edge state=011, door_open=1 for 3 cycles, then state=000.
- Down trip:
  - current=3, target=1, down_request=1 -> state=010, move_down=1.
  - Set current=1 -> DOOR_OPEN for 3 cycles -> IDLE.
- Emergency in IDLE: emergency_stop=1 for 2 cycles -> state=100, stopped=1; deassert -> state=000 next edge.
- Emergency mid-move: in MOVING_UP (current=2, target=3), emergency_stop=1 -> state=100, move_up=0; release with current=3 -> IDLE, with no motion until a new request arrives.
- Wrong-direction/same-floor requests:
  - up_request with target<current -> stays in IDLE.
  - Request with target==current -> DOOR_OPEN when ELEV_SAME_FLOOR_DOOR_EN is defined, IDLE otherwise.
